if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC and runs a req/ack handshake with instruction memory.
- Buffers one fetched instruction and presents pc_incr, instrc and funct to the IF/ID pipeline register with a valid/ready handshake.
- Handles stalls from the hazard unit and branch/jump redirects, including redirects that arrive while a memory access is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment between sequential instructions.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_ready  input  1  consumer can accept; driven as ~stall by the hazard unit.
- redirect  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  target address; bits [1:0] forced to 0.
- imem_req  output  1  memory request; held high until imem_ack.
- imem_addr  output  32  request address; stable while imem_req is high.
- imem_ack  input  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  instruction word.
- fetch_valid  output  1  pc_incr, instrc and funct hold a valid instruction.
- pc_incr  output  32  address of the buffered instruction + PC_STEP.
- instrc  output  32  buffered instruction.
- funct  output  6  instrc[5:0].

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high.
  - pc = RESET_PC; state = REQ.
  - imem_req = 0 in the reset cycle; imem_addr = RESET_PC.
  - fetch_valid = 0, pc_incr = 0, instrc = 0 (NOP), funct = 0.
  - Reset mid-transaction abandons it. A late imem_ack arriving after reset is ignored only if it lands in the reset cycle. Memory must not ack after reset otherwise (system rule).
- Transfer occurs in a cycle where fetch_valid && fetch_ready && !redirect.
- State REQ (imem_req = 1, imem_addr = pc):
  - imem_ack && !redirect: instrc <= imem_rdata; funct <= imem_rdata[5:0]; pc_incr <= pc + PC_STEP; pc <= pc + PC_STEP; fetch_valid <= 1; go to FULL.
  - imem_ack && redirect: data discarded; pc <= redirect_pc; stay in REQ. The new address appears on the next cycle with imem_req still high.
  - !imem_ack && redirect: pc <= redirect_pc; go to DROP. imem_addr keeps the old address, because the address is held in a separate addr register until ack.
  - Zero-wait ack (ack in the first cycle of req) is legal.
- State FULL (imem_req = 0):
  - redirect: fetch_valid <= 0; pc <= redirect_pc; go to REQ. Redirect wins over fetch_ready, so no transfer is counted; the hazard unit flushes IF/ID the same cycle.
  - Transfer: fetch_valid <= 0; go to REQ. This gives one bubble cycle per instruction. Throughput is 1 instruction per (2 + wait) cycles.
  - Otherwise hold: all outputs stable (stall).
- State DROP (imem_req = 1, imem_addr = old address):
  - Waits for the outstanding ack.
  - On imem_ack the data is discarded and the FSM goes to REQ; imem_addr becomes pc next cycle.
  - Further redirects in DROP overwrite pc; the latest target wins.
  - fetch_valid = 0 throughout.
- Arithmetic: pc + PC_STEP is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Invariants:
  - imem_addr never changes while imem_req = 1 and no ack has been seen.
  - fetch_valid = 1 only in FULL.
  - funct always equals instrc[5:0].

Test Plan:
- Reset with RESET_PC = 0, zero-wait memory returning word = address -> three fetches give instrc 0, 4, 8 and pc_incr 4, 8, 12. Each transfer is separated by one bubble cycle.
- Memory acks 3 cycles after req -> imem_req is high 3 cycles with imem_addr constant. fetch_valid rises the cycle after ack.
- Hold fetch_ready = 0 for 5 cycles in FULL with instrc = 32'h0109_5020 -> all outputs held and imem_req = 0. funct = 6'h20. One transfer occurs when ready returns.
- Redirect to 32'h0000_0100 during a 4-cycle wait -> imem_addr stays at the old PC until ack, and that data is dropped. The next request is to 0x100, and the delivered pc_incr = 0x104.
- Redirect in the same cycle as ack, and redirect while FULL with fetch_ready = 1 -> no transfer occurs. fetch_valid = 0 next cycle, and the next imem_addr is redirect_pc.
- Redirect to 32'hFFFF_FFFE -> imem_addr = 32'hFFFF_FFFC and pc_incr = 0. The next fetch is at 0. Assert rst while in DROP -> all outputs match reset values the next cycle.

Source files
------------

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - MIPS IF stage: PC, imem req/ack, one-entry fetch buffer, redirects
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] pc_incr,
  output logic [31:0] instrc,
  output logic [5:0]  funct
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  // REQ: request outstanding at pc; FULL: buffer holds an instruction;
  // DROP: an old request is still in flight and its data must be thrown away.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_FULL = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instrc_q, instrc_d;
  logic [31:0] pc_incr_q, pc_incr_d;
  logic        valid_q, valid_d;

  logic [31:0] redirect_tgt;
  logic [31:0] pc_seq;
  logic        transfer;
  logic        unused_redirect_lsbs;

  // Targets are word aligned; the low two bits of redirect_pc carry no meaning.
  assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign pc_seq               = pc_q + STEP;
  // A redirect in the same cycle flushes IF/ID, so it cancels the hand-over.
  assign transfer             = valid_q && fetch_ready && !redirect;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (imem_ack && !redirect) begin
          state_d = S_FULL;
        end else if (!imem_ack && redirect) begin
          state_d = S_DROP;
        end
      end
      S_FULL: begin
        if (redirect || transfer) begin
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Outputs: the request is masked during reset so a stale FSM state never leaks out
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = RESET_PC;
    fetch_valid = valid_q;
    pc_incr     = pc_incr_q;
    instrc      = instrc_q;
    funct       = instrc_q[5:0];
    if (!rst) begin
      imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
      // In DROP the in-flight address must stay on the bus although pc moved on.
      imem_addr = (state_q == S_DROP) ? addr_q : pc_q;
    end
  end

  // Datapath next-state: pc, held request address and the fetch buffer
  always_comb begin
    pc_d      = pc_q;
    addr_d    = addr_q;
    instrc_d  = instrc_q;
    pc_incr_d = pc_incr_q;
    valid_d   = valid_q;
    case (state_q)
      S_REQ: begin
        // Track pc so that a redirect without ack leaves the live address here.
        addr_d = pc_q;
        if (redirect) begin
          pc_d = redirect_tgt;
        end else if (imem_ack) begin
          instrc_d  = imem_rdata;
          pc_incr_d = pc_seq;
          pc_d      = pc_seq;
          valid_d   = 1'b1;
        end
      end
      S_FULL: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = redirect_tgt;
        end else if (transfer) begin
          valid_d = 1'b0;
        end
      end
      S_DROP: begin
        // The latest redirect target wins; the outstanding data is discarded.
        if (redirect) begin
          pc_d = redirect_tgt;
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      instrc_q  <= 32'h0000_0000;
      pc_incr_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      instrc_q  <= instrc_d;
      pc_incr_q <= pc_incr_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit with memory and stream model
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        fetch_valid;
  logic [31:0] pc_incr;
  logic [31:0] instrc;
  logic [5:0]  funct;

  if_fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_valid(fetch_valid),
    .pc_incr(pc_incr), .instrc(instrc), .funct(funct)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_incr;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          n_xfer = 0;
  logic        rst_drv = 1'b1;
  logic [31:0] model_next = RST_PC;
  logic [31:0] salt = 32'h0;
  int          mem_fixed = 0;
  logic        mem_pending = 1'b0;
  int          mem_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: reference model and inputs at +1, memory responder at +2.
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rst_drv;
    if (rst_drv) begin
      exp_q.delete();
      model_next = RST_PC;
    end else if (rd) begin
      exp_q.delete();
      model_next = {rpc[31:2], 2'b00};
    end else if (fetch_valid && rdy) begin
      e.pc_incr = model_next + 32'd4;
      e.instr   = model_next ^ salt;
      exp_q.push_back(e);
      model_next = model_next + 32'd4;
    end
    fetch_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    imem_ack = 1'b0;
    if (rst) begin
      mem_pending = 1'b0;
    end else if (imem_req) begin
      if (!mem_pending) begin
        mem_pending = 1'b1;
        mem_cnt = (mem_fixed >= 0) ? mem_fixed : int'($urandom_range(0, 3));
      end
      if (mem_cnt == 0) begin
        imem_ack    = 1'b1;
        imem_rdata  = imem_addr ^ salt;
        mem_pending = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    rst_drv = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_fetch_valid", {31'h0, fetch_valid}, 32'h0);
    chk("rst_pc_incr", pc_incr, 32'h0);
    chk("rst_instrc", instrc, 32'h0);
    chk("rst_funct", {26'h0, funct}, 32'h0);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks bus invariants.
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_rst = 1'b1;
  logic [31:0] prev_addr = 32'h0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("funct_eq_instrc", {26'h0, funct}, {26'h0, instrc[5:0]});
      if (!prev_rst && prev_req && !prev_ack && imem_req)
        chk("imem_addr_stable", imem_addr, prev_addr);
      if (fetch_valid && fetch_ready && !redirect) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL xfer_unexpected: got pc_incr %h instrc %h, expected no transfer", pc_incr, instrc);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_pc_incr", pc_incr, e.pc_incr);
          chk("xfer_instrc", instrc, e.instr);
        end
      end
    end
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_rst  = rst;
    prev_addr = imem_addr;
  end

  initial begin
    int x0;
    // Reset values, zero-wait memory returning word = address
    salt = 32'h0;
    mem_fixed = 0;
    do_reset();
    chk_reset_outputs();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("bubble_pattern", {31'h0, fetch_valid}, {31'h0, (i % 2) == 1});
    end

    // Three-cycle request before ack
    do_reset();
    mem_fixed = 2;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("wait_imem_req", {31'h0, imem_req}, 32'h1);
      chk("wait_imem_addr", imem_addr, 32'h0);
      chk("wait_no_valid", {31'h0, fetch_valid}, 32'h0);
    end
    step(1'b1, 1'b0, 32'h0);
    chk("wait_valid_after_ack", {31'h0, fetch_valid}, 32'h1);

    // Stall for five cycles in FULL
    do_reset();
    mem_fixed = 0;
    salt = 32'h0109_5020;
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("stall_valid", {31'h0, fetch_valid}, 32'h1);
      chk("stall_instrc", instrc, 32'h0109_5020);
      chk("stall_funct", {26'h0, funct}, 32'h20);
      chk("stall_pc_incr", pc_incr, 32'h4);
      chk("stall_imem_req", {31'h0, imem_req}, 32'h0);
    end
    x0 = n_xfer;
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("stall_one_xfer", 32'(n_xfer - x0), 32'h1);
    chk("stall_valid_drop", {31'h0, fetch_valid}, 32'h0);

    // Redirect during a four-cycle wait
    do_reset();
    salt = 32'h0;
    mem_fixed = 3;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0100);
    step(1'b1, 1'b0, 32'h0);
    chk("drop_addr_held_a", imem_addr, 32'h0);
    chk("drop_req_a", {31'h0, imem_req}, 32'h1);
    step(1'b1, 1'b0, 32'h0);
    chk("drop_addr_held_b", imem_addr, 32'h0);
    mem_fixed = 0;
    step(1'b1, 1'b0, 32'h0);
    chk("drop_new_addr", imem_addr, 32'h0000_0100);
    chk("drop_new_req", {31'h0, imem_req}, 32'h1);
    chk("drop_no_valid", {31'h0, fetch_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("drop_pc_incr", pc_incr, 32'h0000_0104);

    // Redirect with ack, then redirect while FULL and ready
    do_reset();
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b0, 32'h0);
    chk("ackredir_valid", {31'h0, fetch_valid}, 32'h0);
    chk("ackredir_addr", imem_addr, 32'h0000_0200);
    step(1'b1, 1'b1, 32'h0000_0300);
    chk("fullredir_valid_before", {31'h0, fetch_valid}, 32'h1);
    x0 = n_xfer;
    step(1'b1, 1'b0, 32'h0);
    chk("fullredir_valid", {31'h0, fetch_valid}, 32'h0);
    chk("fullredir_addr", imem_addr, 32'h0000_0300);
    chk("fullredir_no_xfer", 32'(n_xfer - x0), 32'h0);
    step(1'b1, 1'b0, 32'h0);

    // Unaligned target at top of memory, wrap, then reset while in DROP
    do_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFFE);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    mem_fixed = 3;
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_pc_incr", pc_incr, 32'h0);
    chk("wrap_instrc", instrc, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0040);
    step(1'b1, 1'b0, 32'h0);
    chk("rstdrop_req", {31'h0, imem_req}, 32'h1);
    chk("rstdrop_addr", imem_addr, 32'h0);
    rst_drv = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk_reset_outputs();
    rst_drv = 1'b0;

    // Randomized traffic against the stream model
    do_reset();
    salt = $urandom;
    mem_fixed = -1;
    x0 = n_xfer;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        rst_drv = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        rst_drv = 1'b0;
      end else begin
        step(($urandom % 4) != 0, ($urandom % 8) == 0, $urandom);
      end
    end
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    chk("random_progress", {31'h0, (n_xfer - x0) > 100}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
